// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: widths, grant encoding
// and the one-hot destination decode also used by the register file itself.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_req_slot.sv
// One-entry holding slot for a register-file write request; it can take a new
// request in the same cycle its current one is granted.
module req_slot
    import regfile_pkg::*;
#(
    parameter int SLOT_DATA_W = regfile_pkg::DATA_W,
    parameter int SLOT_ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [SLOT_ADDR_W-1:0] dr,
    input  logic [SLOT_DATA_W-1:0] data,
    input  logic                   grant,
    output logic                   ready,
    output logic                   full,
    output logic [SLOT_ADDR_W-1:0] slot_dr,
    output logic [SLOT_DATA_W-1:0] slot_data
);

    logic                   full_q, full_d;
    logic [SLOT_ADDR_W-1:0] dr_q, dr_d;
    logic [SLOT_DATA_W-1:0] data_q, data_d;

    assign ready     = !full_q || grant;
    assign full      = full_q;
    assign slot_dr   = dr_q;
    assign slot_data = data_q;

    // A refill on the draining edge wins over the clear.
    always_comb begin
        full_d = full_q;
        dr_d   = dr_q;
        data_d = data_q;
        if (valid && ready) begin
            full_d = 1'b1;
            dr_d   = dr;
            data_d = data;
        end else if (grant) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            dr_q   <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            dr_q   <= dr_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port between the ALU (A) and
// memory-load (B) paths, with a mask of registers that still have writes in flight.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_dr,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_dr,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    output logic                regWE,
    output logic [ADDR_W-1:0]   DR,
    output logic [DATA_W-1:0]   Buss,
    output logic [NUM_REGS-1:0] pending
);

    logic              full_a, full_b;
    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] a_slot_dr, b_slot_dr;
    logic [DATA_W-1:0] a_slot_data, b_slot_data;

    logic              regwe_q, regwe_d;
    logic [ADDR_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] buss_q, buss_d;
    grant_e            last_grant_q, last_grant_d;

    req_slot #(
        .SLOT_DATA_W (DATA_W),
        .SLOT_ADDR_W (ADDR_W)
    ) u_slot_a (
        .clk       (clk),
        .reset     (reset),
        .valid     (a_valid),
        .dr        (a_dr),
        .data      (a_data),
        .grant     (grant_a),
        .ready     (a_ready),
        .full      (full_a),
        .slot_dr   (a_slot_dr),
        .slot_data (a_slot_data)
    );

    req_slot #(
        .SLOT_DATA_W (DATA_W),
        .SLOT_ADDR_W (ADDR_W)
    ) u_slot_b (
        .clk       (clk),
        .reset     (reset),
        .valid     (b_valid),
        .dr        (b_dr),
        .data      (b_data),
        .grant     (grant_b),
        .ready     (b_ready),
        .full      (full_b),
        .slot_dr   (b_slot_dr),
        .slot_data (b_slot_data)
    );

    // Under contention the slot that did not win last time is served.
    assign grant_a = full_a && (!full_b || (last_grant_q == GRANT_B));
    assign grant_b = full_b && (!full_a || (last_grant_q == GRANT_A));

    always_comb begin
        regwe_d      = grant_a || grant_b;
        dr_d         = dr_q;
        buss_d       = buss_q;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            dr_d         = a_slot_dr;
            buss_d       = a_slot_data;
            last_grant_d = GRANT_A;
        end else if (grant_b) begin
            dr_d         = b_slot_dr;
            buss_d       = b_slot_data;
            last_grant_d = GRANT_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwe_q      <= 1'b0;
            dr_q         <= '0;
            buss_q       <= '0;
            last_grant_q <= GRANT_B;
        end else begin
            regwe_q      <= regwe_d;
            dr_q         <= dr_d;
            buss_q       <= buss_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign regWE = regwe_q;
    assign DR    = dr_q;
    assign Buss  = buss_q;

    // A register stays pending until the port cycle that writes it has passed.
    assign pending = (decode(a_slot_dr) & {NUM_REGS{full_a}})
                   | (decode(b_slot_dr) & {NUM_REGS{full_b}})
                   | (decode(dr_q)      & {NUM_REGS{regwe_q}});

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single writes, contention order,
// streaming, same-register ordering, alternation and reset with full slots.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [2:0]  a_dr, b_dr;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        regWE;
    logic [2:0]  DR;
    logic [15:0] Buss;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;
    int ai, bi;
    logic exp_ar, exp_br;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_dr    (a_dr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_dr    (b_dr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .regWE   (regWE),
        .DR      (DR),
        .Buss    (Buss),
        .pending (pending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [2:0] d, input logic [15:0] bus);
        chk({tag, "_we"}, 32'(regWE), 32'(we));
        chk({tag, "_dr"}, 32'(DR), 32'(d));
        chk({tag, "_buss"}, 32'(Buss), 32'(bus));
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_dr = '0; a_data = '0;
        b_valid = 1'b0; b_dr = '0; b_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk_port("rst", 1'b0, 3'd0, 16'h0000);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_a_ready", 32'(a_ready), 32'h1);
        chk("rst_b_ready", 32'(b_ready), 32'h1);

        // A alone: dr=3, 0x1234
        a_valid = 1'b1; a_dr = 3'd3; a_data = 16'h1234;
        #1 chk("t1_a_ready0", 32'(a_ready), 32'h1);
        tick();
        a_valid = 1'b0;
        chk("t1_pend_slot", 32'(pending), 32'h08);
        chk("t1_we_before", 32'(regWE), 32'h0);
        chk("t1_a_ready1", 32'(a_ready), 32'h1);
        tick();
        chk_port("t1_issue", 1'b1, 3'd3, 16'h1234);
        chk("t1_pend_port", 32'(pending), 32'h08);
        tick();
        chk_port("t1_idle", 1'b0, 3'd3, 16'h1234);
        chk("t1_pend_clear", 32'(pending), 32'h00);

        // Simultaneous accept after reset: A first
        do_reset();
        a_valid = 1'b1; a_dr = 3'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_dr = 3'd2; b_data = 16'hBBBB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t2_pend", 32'(pending), 32'h06);
        chk("t2_a_ready", 32'(a_ready), 32'h1);
        chk("t2_b_ready", 32'(b_ready), 32'h0);
        tick();
        chk_port("t2_first", 1'b1, 3'd1, 16'hAAAA);
        chk("t2_pend_mid", 32'(pending), 32'h06);
        chk("t2_b_ready_g", 32'(b_ready), 32'h1);
        tick();
        chk_port("t2_second", 1'b1, 3'd2, 16'hBBBB);
        chk("t2_pend_last", 32'(pending), 32'h04);
        tick();
        chk("t2_idle_we", 32'(regWE), 32'h0);

        // A alone once (last grant becomes A), then contention: B first
        a_valid = 1'b1; a_dr = 3'd4; a_data = 16'h4444;
        tick();
        a_valid = 1'b0;
        tick();
        chk_port("t2b_single", 1'b1, 3'd4, 16'h4444);
        a_valid = 1'b1; a_dr = 3'd1; a_data = 16'hA1A1;
        b_valid = 1'b1; b_dr = 3'd2; b_data = 16'hB2B2;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t2b_a_ready", 32'(a_ready), 32'h0);
        tick();
        chk_port("t2b_first", 1'b1, 3'd2, 16'hB2B2);
        tick();
        chk_port("t2b_second", 1'b1, 3'd1, 16'hA1A1);
        tick();
        chk("t2b_idle", 32'(regWE), 32'h0);

        // A streams dr=0..7 back to back
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1;
            a_dr    = 3'(i);
            a_data  = 16'(i * 16'h0101);
            #1 chk($sformatf("t3_a_ready%0d", i), 32'(a_ready), 32'h1);
            tick();
            if (i > 0)
                chk_port($sformatf("t3_w%0d", i - 1), 1'b1, 3'(i - 1), 16'((i - 1) * 16'h0101));
        end
        a_valid = 1'b0;
        tick();
        chk_port("t3_w7", 1'b1, 3'd7, 16'h0707);
        tick();
        chk("t3_idle", 32'(regWE), 32'h0);

        // Both slots dr=5 with last grant A: B then A, A final
        a_valid = 1'b1; a_dr = 3'd5; a_data = 16'h0001;
        b_valid = 1'b1; b_dr = 3'd5; b_data = 16'h0002;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t4_pend", 32'(pending), 32'h20);
        tick();
        chk_port("t4_first", 1'b1, 3'd5, 16'h0002);
        chk("t4_pend1", 32'(pending), 32'h20);
        tick();
        chk_port("t4_second", 1'b1, 3'd5, 16'h0001);
        chk("t4_pend2", 32'(pending), 32'h20);
        tick();
        chk("t4_pend_clear", 32'(pending), 32'h00);
        chk("t4_idle", 32'(regWE), 32'h0);

        // B continuously valid while A streams: grants alternate A,B,A,B
        do_reset();
        a_valid = 1'b1; a_dr = 3'd1;
        b_valid = 1'b1; b_dr = 3'd2;
        ai = 0; bi = 0;
        for (int c = 0; c < 7; c++) begin
            a_data = 16'hA000 + 16'(ai);
            b_data = 16'hB000 + 16'(bi);
            exp_ar = (c == 0) ? 1'b1 : (c % 2 == 1);
            exp_br = (c == 0) ? 1'b1 : (c % 2 == 0);
            #1;
            chk($sformatf("t5_a_ready_c%0d", c), 32'(a_ready), 32'(exp_ar));
            chk($sformatf("t5_b_ready_c%0d", c), 32'(b_ready), 32'(exp_br));
            tick();
            if (exp_ar) ai++;
            if (exp_br) bi++;
            if (c >= 1) begin
                if (c % 2 == 1)
                    chk_port($sformatf("t5_issue_c%0d", c), 1'b1, 3'd1, 16'hA000 + 16'((c - 1) / 2));
                else
                    chk_port($sformatf("t5_issue_c%0d", c), 1'b1, 3'd2, 16'hB000 + 16'(c / 2 - 1));
            end
        end

        // Reset with both slots full: held writes dropped
        chk("t6_pend_full", 32'(pending), 32'h06);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk_port("t6_after_rst", 1'b0, 3'd0, 16'h0000);
        chk("t6_pend", 32'(pending), 32'h00);
        chk("t6_a_ready", 32'(a_ready), 32'h1);
        chk("t6_b_ready", 32'(b_ready), 32'h1);
        tick();
        chk_port("t6_next", 1'b0, 3'd0, 16'h0000);
        tick();
        chk_port("t6_next2", 1'b0, 3'd0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
